// File: rtl/usb_pkg.sv
// Shared definitions for the USB device responder:
// PID codes, packet field positions and FSM states.
package usb_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  localparam int PKT_W    = 99;
  localparam int PID_MSB  = 98;
  localparam int PID_LSB  = 91;
  localparam int ADDR_MSB = 90;
  localparam int ADDR_LSB = 84;
  localparam int ENDP_MSB = 83;
  localparam int ENDP_LSB = 80;
  localparam int DATA_MSB = 79;
  localparam int DATA_LSB = 16;
  localparam int CRC_MSB  = 15;
  localparam int CRC_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    OUT_DATA,
    IN_WAIT_HS,
    SEND,
    DRAIN
  } state_e;

  // CRC is left zero; the encoder computes and inserts it.
  function automatic logic [PKT_W-1:0] mk_pkt(
    input logic [7:0]  pid,
    input logic [6:0]  addr,
    input logic [3:0]  endp,
    input logic [63:0] data
  );
    logic [PKT_W-1:0] p;
    p                    = '0;
    p[PID_MSB:PID_LSB]   = pid;
    p[ADDR_MSB:ADDR_LSB] = addr;
    p[ENDP_MSB:ENDP_LSB] = endp;
    p[DATA_MSB:DATA_LSB] = data;
    p[CRC_MSB:CRC_LSB]   = 16'h0000;
    return p;
  endfunction

endpackage

// File: rtl/usb_timeout_ctr.sv
// Saturating wait counter; done holds once the
// count reaches TIMEOUT until cleared.
module usb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_device_responder.sv
// Single-endpoint USB device responder: handles OUT/IN
// transactions and drives handshakes to the encoder.
module usb_device_responder
  import usb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'd5,
  parameter logic [3:0] DEV_ENDP = 4'd4,
  parameter int         TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [PKT_W-1:0]  pkt_in,
  input  logic              pkt_in_avail,
  input  logic              data_good,
  input  logic              encoder_ready,
  input  logic              tx_busy,
  output logic [PKT_W-1:0]  pkt_out,
  output logic              pkt_out_avail,
  output logic              re,
  output logic [63:0]       ep_data,
  output logic              ep_valid,
  output logic              err
);

  state_e            state_q, state_d;
  logic [PKT_W-1:0]  pkt_out_q, pkt_out_d;
  logic              pkt_out_avail_q, pkt_out_avail_d;
  logic [63:0]       ep_data_q, ep_data_d;
  logic              ep_valid_q, ep_valid_d;
  logic              err_q, err_d;
  logic              sent_data_q, sent_data_d;

  logic [7:0]  in_pid;
  logic [6:0]  in_addr;
  logic [3:0]  in_endp;
  logic [63:0] in_data;
  logic        tok_hit;
  logic        tmr_en;
  logic        tmr_done;
  logic        unused_crc;

  assign in_pid     = pkt_in[PID_MSB:PID_LSB];
  assign in_addr    = pkt_in[ADDR_MSB:ADDR_LSB];
  assign in_endp    = pkt_in[ENDP_MSB:ENDP_LSB];
  assign in_data    = pkt_in[DATA_MSB:DATA_LSB];
  assign unused_crc = ^pkt_in[CRC_MSB:CRC_LSB];
  assign tok_hit    = (in_addr == DEV_ADDR) && (in_endp == DEV_ENDP);

  // Counter sits at zero outside the listening states.
  assign tmr_en = (state_q == OUT_DATA) || (state_q == IN_WAIT_HS);

  usb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmr (
    .clk   (clk),
    .rst_b (rst_b),
    .clear (!tmr_en),
    .enable(tmr_en),
    .done  (tmr_done)
  );

  always_comb begin
    state_d         = state_q;
    pkt_out_d       = pkt_out_q;
    pkt_out_avail_d = pkt_out_avail_q;
    ep_data_d       = ep_data_q;
    ep_valid_d      = ep_valid_q;
    err_d           = 1'b0;
    sent_data_d     = sent_data_q;
    unique case (state_q)
      IDLE: begin
        if (pkt_in_avail) begin
          if (in_pid == PID_OUT) begin
            if (tok_hit) state_d = OUT_DATA;
          end else if (in_pid == PID_IN) begin
            if (tok_hit) begin
              state_d         = SEND;
              pkt_out_avail_d = 1'b1;
              sent_data_d     = ep_valid_q;
              pkt_out_d       = ep_valid_q
                ? mk_pkt(PID_DATA0, DEV_ADDR, DEV_ENDP, ep_data_q)
                : mk_pkt(PID_NAK, DEV_ADDR, DEV_ENDP, 64'd0);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      OUT_DATA: begin
        if (pkt_in_avail) begin
          if (in_pid == PID_DATA0) begin
            state_d         = SEND;
            pkt_out_avail_d = 1'b1;
            sent_data_d     = 1'b0;
            if (data_good) begin
              ep_data_d  = in_data;
              ep_valid_d = 1'b1;
              pkt_out_d  = mk_pkt(PID_ACK, DEV_ADDR, DEV_ENDP, 64'd0);
            end else begin
              err_d     = 1'b1;
              pkt_out_d = mk_pkt(PID_NAK, DEV_ADDR, DEV_ENDP, 64'd0);
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmr_done) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      IN_WAIT_HS: begin
        if (pkt_in_avail) begin
          state_d = IDLE;
          if (in_pid == PID_ACK) begin
            ep_valid_d = 1'b0;
          end else if (in_pid != PID_NAK) begin
            err_d = 1'b1;
          end
        end else if (tmr_done) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (encoder_ready) begin
          pkt_out_avail_d = 1'b0;
          state_d         = DRAIN;
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          state_d = sent_data_q ? IN_WAIT_HS : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q         <= IDLE;
      pkt_out_q       <= '0;
      pkt_out_avail_q <= 1'b0;
      ep_data_q       <= '0;
      ep_valid_q      <= 1'b0;
      err_q           <= 1'b0;
      sent_data_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      pkt_out_q       <= pkt_out_d;
      pkt_out_avail_q <= pkt_out_avail_d;
      ep_data_q       <= ep_data_d;
      ep_valid_q      <= ep_valid_d;
      err_q           <= err_d;
      sent_data_q     <= sent_data_d;
    end
  end

  assign pkt_out       = pkt_out_q;
  assign pkt_out_avail = pkt_out_avail_q;
  assign ep_data       = ep_data_q;
  assign ep_valid      = ep_valid_q;
  assign err           = err_q;
  assign re            = !((state_q == SEND) || (state_q == DRAIN));

endmodule

// File: tb/tb_usb_device_responder.sv
// Scoreboard bench for usb_device_responder: expected
// outbound packets are queued, a monitor checks transfers.
module tb_usb_device_responder;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic [98:0] pkt_in = '0;
  logic        pkt_in_avail = 1'b0;
  logic        data_good = 1'b0;
  logic        encoder_ready = 1'b1;
  logic        tx_busy = 1'b0;
  logic [98:0] pkt_out;
  logic        pkt_out_avail;
  logic        re;
  logic [63:0] ep_data;
  logic        ep_valid;
  logic        err;

  localparam logic [7:0] P_OUT = 8'hE1;
  localparam logic [7:0] P_IN  = 8'h69;
  localparam logic [7:0] P_D0  = 8'hC3;
  localparam logic [7:0] P_ACK = 8'hD2;
  localparam logic [7:0] P_NAK = 8'h5A;

  localparam logic [63:0] D1 = 64'hDEADBEEF_01234567;
  localparam logic [63:0] D2 = 64'h11223344_55667788;
  localparam logic [63:0] D3 = 64'hCAFEF00D_0BADC0DE;

  usb_device_responder #(
    .DEV_ADDR(7'd5),
    .DEV_ENDP(4'd4),
    .TIMEOUT (255)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .pkt_in       (pkt_in),
    .pkt_in_avail (pkt_in_avail),
    .data_good    (data_good),
    .encoder_ready(encoder_ready),
    .tx_busy      (tx_busy),
    .pkt_out      (pkt_out),
    .pkt_out_avail(pkt_out_avail),
    .re           (re),
    .ep_data      (ep_data),
    .ep_valid     (ep_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int e0;
  logic [98:0] exp_q[$];

  function automatic logic [98:0] mk(
    input logic [7:0] pid, input logic [6:0] a,
    input logic [3:0] e, input logic [63:0] d);
    return {pid, a, e, d, 16'h0000};
  endfunction

  task automatic chk(input string nm,
                     input logic [98:0] act,
                     input logic [98:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b && err) err_cnt++;
    if (rst_b && pkt_out_avail && encoder_ready) begin
      chk("re_during_tx", 99'(re), 99'(0));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_unexpected: got %0h want none", pkt_out);
      end else begin
        chk("tx_pkt", pkt_out, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] pid, input logic [6:0] a,
                      input logic [3:0] e, input logic [63:0] d,
                      input logic g);
    @(posedge clk);
    #1;
    pkt_in       = mk(pid, a, e, d);
    pkt_in_avail = 1'b1;
    data_good    = g;
    @(posedge clk);
    #1;
    pkt_in       = '0;
    pkt_in_avail = 1'b0;
    data_good    = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pkt_out"}, pkt_out, '0);
    chk({tag, "_avail"}, 99'(pkt_out_avail), 99'(0));
    chk({tag, "_re"}, 99'(re), 99'(1));
    chk({tag, "_ep_data"}, 99'(ep_data), 99'(0));
    chk({tag, "_ep_valid"}, 99'(ep_valid), 99'(0));
    chk({tag, "_err"}, 99'(err), 99'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1 rst_b = 1'b0;
    #2;
    chk_reset("por");
    @(negedge clk);
    rst_b = 1'b1;
    cyc(2);

    // OUT + good DATA0 -> ACK, data latched
    e0 = err_cnt;
    exp_q.push_back(mk(P_ACK, 7'd5, 4'd4, 64'd0));
    send(P_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
    send(P_D0, 7'd0, 4'd0, D1, 1'b1);
    cyc(6);
    chk("t1_ep_data", 99'(ep_data), 99'(D1));
    chk("t1_ep_valid", 99'(ep_valid), 99'(1));
    chk("t1_err", 99'(err_cnt - e0), 99'(0));
    chk("t1_sb", 99'(exp_q.size()), 99'(0));

    // IN with data -> DATA0, drain held by tx_busy, host ACK
    e0 = err_cnt;
    tx_busy = 1'b1;
    exp_q.push_back(mk(P_D0, 7'd5, 4'd4, D1));
    send(P_IN, 7'd5, 4'd4, 64'd0, 1'b1);
    cyc(4);
    chk("t2_re_drain", 99'(re), 99'(0));
    chk("t2_avail_drain", 99'(pkt_out_avail), 99'(0));
    tx_busy = 1'b0;
    cyc(2);
    chk("t2_re_wait", 99'(re), 99'(1));
    chk("t2_ep_valid_pre", 99'(ep_valid), 99'(1));
    send(P_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
    cyc(2);
    chk("t2_ep_valid", 99'(ep_valid), 99'(0));
    chk("t2_err", 99'(err_cnt - e0), 99'(0));

    // IN with nothing buffered -> NAK
    e0 = err_cnt;
    exp_q.push_back(mk(P_NAK, 7'd5, 4'd4, 64'd0));
    send(P_IN, 7'd5, 4'd4, 64'd0, 1'b1);
    cyc(5);
    chk("t3_ep_valid", 99'(ep_valid), 99'(0));
    chk("t3_err", 99'(err_cnt - e0), 99'(0));
    chk("t3_re", 99'(re), 99'(1));
    chk("t3_sb", 99'(exp_q.size()), 99'(0));

    // bad CRC on DATA0 -> err + NAK, data kept
    e0 = err_cnt;
    exp_q.push_back(mk(P_NAK, 7'd5, 4'd4, 64'd0));
    send(P_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
    send(P_D0, 7'd0, 4'd0, D3, 1'b0);
    cyc(6);
    chk("t4_err", 99'(err_cnt - e0), 99'(1));
    chk("t4_ep_data", 99'(ep_data), 99'(D1));
    chk("t4_ep_valid", 99'(ep_valid), 99'(0));

    // IN with no host handshake -> timeout
    exp_q.push_back(mk(P_ACK, 7'd5, 4'd4, 64'd0));
    send(P_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
    send(P_D0, 7'd0, 4'd0, D2, 1'b1);
    cyc(6);
    e0 = err_cnt;
    exp_q.push_back(mk(P_D0, 7'd5, 4'd4, D2));
    send(P_IN, 7'd5, 4'd4, 64'd0, 1'b1);
    cyc(248);
    chk("t5_no_early_to", 99'(err_cnt - e0), 99'(0));
    chk("t5_re_wait", 99'(re), 99'(1));
    cyc(16);
    chk("t5_to_err", 99'(err_cnt - e0), 99'(1));
    chk("t5_ep_valid", 99'(ep_valid), 99'(1));
    chk("t5_ep_data", 99'(ep_data), 99'(D2));

    // unexpected PID in IDLE, foreign tokens ignored
    e0 = err_cnt;
    send(P_ACK, 7'd5, 4'd4, 64'd0, 1'b1);
    cyc(3);
    chk("t6_bad_pid_err", 99'(err_cnt - e0), 99'(1));
    e0 = err_cnt;
    send(P_OUT, 7'd3, 4'd4, 64'd0, 1'b1);
    cyc(2);
    chk("t6_addr_no_err", 99'(err_cnt - e0), 99'(0));
    send(P_D0, 7'd0, 4'd0, D3, 1'b1);
    cyc(3);
    chk("t6_d0_idle_err", 99'(err_cnt - e0), 99'(1));
    chk("t6_ep_data", 99'(ep_data), 99'(D2));
    e0 = err_cnt;
    send(P_IN, 7'd5, 4'd2, 64'd0, 1'b1);
    cyc(4);
    chk("t6_endp_no_err", 99'(err_cnt - e0), 99'(0));
    chk("t6_re", 99'(re), 99'(1));

    // reset while a DATA0 is stalled by the encoder
    encoder_ready = 1'b0;
    send(P_IN, 7'd5, 4'd4, 64'd0, 1'b1);
    cyc(3);
    chk("t7_avail", 99'(pkt_out_avail), 99'(1));
    chk("t7_pkt", pkt_out, mk(P_D0, 7'd5, 4'd4, D2));
    chk("t7_re", 99'(re), 99'(0));
    #2 rst_b = 1'b0;
    #1;
    chk_reset("t7_rst");
    encoder_ready = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    cyc(3);
    chk("t7_post_avail", 99'(pkt_out_avail), 99'(0));
    chk("t7_post_re", 99'(re), 99'(1));
    chk("final_sb", 99'(exp_q.size()), 99'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
